// File: rtl/extensor_pkg.sv
// Shared types and constants for the pipelined immediate extender.
// Load sel codes are only meaningful when EXTENSOR_LOAD_EN is defined.
package extensor_pkg;

   typedef enum logic [2:0] {
      FMT_I       = 3'd0,
      FMT_S       = 3'd1,
      FMT_SB      = 3'd2,
      FMT_U       = 3'd3,
      FMT_UJ      = 3'd4,
      FMT_SHAMT   = 3'd5,
      FMT_LOAD    = 3'd6,
      FMT_ILLEGAL = 3'd7
   } fmt_t;

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [3:0] SEL_LB  = 4'd8;
   localparam logic [3:0] SEL_LH  = 4'd9;
   localparam logic [3:0] SEL_LW  = 4'd10;
   localparam logic [3:0] SEL_LD  = 4'd11;
   localparam logic [3:0] SEL_LBU = 4'd12;
   localparam logic [3:0] SEL_LHU = 4'd13;
   localparam logic [3:0] SEL_LWU = 4'd14;

endpackage

// File: rtl/extensor_core.sv
// Combinational immediate extraction and opcode auto-decode.
// EXTENSOR_LOAD_EN adds load-data extraction (sel 8-14).
module extensor_core
   import extensor_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [31:0]     instr,
   input  logic [3:0]      sel,
   input  logic            auto_sel,
`ifdef EXTENSOR_LOAD_EN
   input  logic [XLEN-1:0] ld_data,
   input  logic [2:0]      ld_off,
`endif
   output logic [XLEN-1:0] imm,
   output fmt_t            fmt,
   output logic            err
);

   logic [6:0]  opcode_s;
   logic [2:0]  funct3_s;
   fmt_t        fmt_s;
   logic [63:0] imm64_s;

   assign opcode_s = instr[6:0];
   assign funct3_s = instr[14:12];

`ifdef EXTENSOR_LOAD_EN
   logic [63:0] ld_shift_s;
   logic [63:0] ld_val_s;
   logic        ld_legal_s;
   logic        ld_in_range_s;

   // Offsets past the data word only exist for the narrow datapath.
   assign ld_shift_s    = 64'(ld_data) >> {ld_off, 3'b000};
   assign ld_in_range_s = (XLEN == 64) || (ld_off[2] == 1'b0);

   // Select and extend the addressed load field; flag misalignment.
   always_comb begin
      ld_val_s   = 64'd0;
      ld_legal_s = 1'b0;
      case (sel)
         SEL_LB:  begin ld_val_s = {{56{ld_shift_s[7]}}, ld_shift_s[7:0]};    ld_legal_s = ld_in_range_s; end
         SEL_LH:  begin ld_val_s = {{48{ld_shift_s[15]}}, ld_shift_s[15:0]};  ld_legal_s = ld_in_range_s && (ld_off[0] == 1'b0); end
         SEL_LW:  begin ld_val_s = {{32{ld_shift_s[31]}}, ld_shift_s[31:0]};  ld_legal_s = ld_in_range_s && (ld_off[1:0] == 2'b00); end
         SEL_LD:  begin ld_val_s = ld_shift_s;                                 ld_legal_s = (XLEN == 64) && (ld_off == 3'b000); end
         SEL_LBU: begin ld_val_s = {56'd0, ld_shift_s[7:0]};                   ld_legal_s = ld_in_range_s; end
         SEL_LHU: begin ld_val_s = {48'd0, ld_shift_s[15:0]};                  ld_legal_s = ld_in_range_s && (ld_off[0] == 1'b0); end
         SEL_LWU: begin ld_val_s = {32'd0, ld_shift_s[31:0]};                  ld_legal_s = (XLEN == 64) && (ld_off[1:0] == 2'b00); end
         default: begin ld_val_s = 64'd0;                                      ld_legal_s = 1'b0; end
      endcase
   end
`endif

   // Format decision: opcode table when auto_sel, otherwise the sel code.
   always_comb begin
      fmt_s = FMT_ILLEGAL;
      if (auto_sel) begin
         case (opcode_s)
            OP_IMM: begin
               if ((funct3_s == 3'b001) || (funct3_s == 3'b101)) fmt_s = FMT_SHAMT;
               else                                               fmt_s = FMT_I;
            end
            OP_LOAD, OP_JALR, OP_SYSTEM: fmt_s = FMT_I;
            OP_STORE:                    fmt_s = FMT_S;
            OP_BRANCH:                   fmt_s = FMT_SB;
            OP_LUI, OP_AUIPC:            fmt_s = FMT_U;
            OP_JAL:                      fmt_s = FMT_UJ;
            default:                     fmt_s = FMT_ILLEGAL;
         endcase
      end else begin
         case (sel)
            4'd0:    fmt_s = FMT_I;
            4'd1:    fmt_s = FMT_S;
            4'd2:    fmt_s = FMT_SB;
            4'd3:    fmt_s = FMT_U;
            4'd4:    fmt_s = FMT_UJ;
            4'd5:    fmt_s = FMT_SHAMT;
`ifdef EXTENSOR_LOAD_EN
            SEL_LB, SEL_LH, SEL_LW, SEL_LD, SEL_LBU, SEL_LHU, SEL_LWU: begin
               if (ld_legal_s) fmt_s = FMT_LOAD;
               else            fmt_s = FMT_ILLEGAL;
            end
`endif
            default: fmt_s = FMT_ILLEGAL;
         endcase
      end
   end

   // Build the full 64-bit immediate; narrow datapaths take the low bits.
   always_comb begin
      imm64_s = 64'd0;
      case (fmt_s)
         FMT_I:     imm64_s = {{52{instr[31]}}, instr[31:20]};
         FMT_S:     imm64_s = {{52{instr[31]}}, instr[31:25], instr[11:7]};
         FMT_SB:    imm64_s = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         FMT_U:     imm64_s = {{32{instr[31]}}, instr[31:12], 12'd0};
         FMT_UJ:    imm64_s = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         FMT_SHAMT: imm64_s = (XLEN == 64) ? {58'd0, instr[25:20]} : {59'd0, instr[24:20]};
`ifdef EXTENSOR_LOAD_EN
         FMT_LOAD:  imm64_s = ld_val_s;
`endif
         default:   imm64_s = 64'd0;
      endcase
   end

   assign imm = imm64_s[XLEN-1:0];
   assign fmt = fmt_s;
   assign err = (fmt_s == FMT_ILLEGAL);

endmodule

// File: rtl/extensor_pipe.sv
// Buffered immediate extender: valid/ready input, DEPTH-entry result FIFO,
// saturating illegal-entry counter. Optional loads via EXTENSOR_LOAD_EN.
module extensor_pipe
   import extensor_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter int DEPTH = 2,
   parameter int ERRW  = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instr,
   input  logic [3:0]      sel,
   input  logic            auto_sel,
`ifdef EXTENSOR_LOAD_EN
   input  logic [XLEN-1:0] ld_data,
   input  logic [2:0]      ld_off,
`endif
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] imm,
   output logic [2:0]      fmt,
   output logic            err,
   output logic [ERRW-1:0] err_count
);

   localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNTW = PTRW + 1;

   logic [XLEN-1:0] core_imm_s;
   fmt_t            core_fmt_s;
   logic            core_err_s;

   logic [XLEN-1:0] imm_mem_q [DEPTH];
   fmt_t            fmt_mem_q [DEPTH];
   logic            err_mem_q [DEPTH];

   logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0] count_q, count_d;
   logic [ERRW-1:0] err_count_q, err_count_d;
   logic            in_ready_q, out_valid_q;
   logic            accept_s, pop_s;

   extensor_core #(.XLEN(XLEN)) u_core (
      .instr    (instr),
      .sel      (sel),
      .auto_sel (auto_sel),
`ifdef EXTENSOR_LOAD_EN
      .ld_data  (ld_data),
      .ld_off   (ld_off),
`endif
      .imm      (core_imm_s),
      .fmt      (core_fmt_s),
      .err      (core_err_s)
   );

   // flush wins over a same-cycle accept, so the word is never stored or counted.
   assign accept_s = in_valid & in_ready_q & ~flush;
   assign pop_s    = out_valid_q & out_ready;

   // Next-state for pointers, occupancy and the saturating error counter.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      err_count_d = err_count_q;
      if (flush) begin
         wr_ptr_d = {PTRW{1'b0}};
         rd_ptr_d = {PTRW{1'b0}};
         count_d  = {CNTW{1'b0}};
      end else begin
         if (accept_s) wr_ptr_d = wr_ptr_q + PTRW'(1);
         else          wr_ptr_d = wr_ptr_q;
         if (pop_s)    rd_ptr_d = rd_ptr_q + PTRW'(1);
         else          rd_ptr_d = rd_ptr_q;
         case ({accept_s, pop_s})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
         endcase
      end
      if (accept_s && core_err_s && (err_count_q != {ERRW{1'b1}})) err_count_d = err_count_q + ERRW'(1);
      else                                                         err_count_d = err_count_q;
   end

   // State registers and FIFO storage; handshake flags registered from count_d.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q    <= {PTRW{1'b0}};
         rd_ptr_q    <= {PTRW{1'b0}};
         count_q     <= {CNTW{1'b0}};
         err_count_q <= {ERRW{1'b0}};
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            imm_mem_q[i] <= {XLEN{1'b0}};
            fmt_mem_q[i] <= FMT_I;
            err_mem_q[i] <= 1'b0;
         end
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         err_count_q <= err_count_d;
         in_ready_q  <= (count_d != CNTW'(DEPTH));
         out_valid_q <= (count_d != {CNTW{1'b0}});
         if (accept_s) begin
            imm_mem_q[wr_ptr_q] <= core_imm_s;
            fmt_mem_q[wr_ptr_q] <= core_fmt_s;
            err_mem_q[wr_ptr_q] <= core_err_s;
         end
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign imm       = imm_mem_q[rd_ptr_q];
   assign fmt       = fmt_mem_q[rd_ptr_q];
   assign err       = err_mem_q[rd_ptr_q];
   assign err_count = err_count_q;

endmodule

// File: tb/tb_extensor_pipe.sv
// Scoreboard bench for extensor_pipe: driver pushes expected results from an
// arithmetic reference model; a negedge monitor pops and compares on each pop.
module tb_extensor_pipe;

   localparam int XLEN  = 64;
   localparam int DEPTH = 2;
   localparam int ERRW  = 16;
`ifdef EXTENSOR_LOAD_EN
   localparam bit LOAD_EN = 1'b1;
`else
   localparam bit LOAD_EN = 1'b0;
`endif

   typedef struct {
      logic [63:0] imm;
      logic [2:0]  fmt;
      logic        err;
   } exp_t;

   logic            clk = 1'b0;
   logic            reset, flush, in_valid, in_ready, auto_sel;
   logic [31:0]     instr;
   logic [3:0]      sel;
   logic            out_valid, out_ready, err;
   logic [XLEN-1:0] imm;
   logic [2:0]      fmt;
   logic [ERRW-1:0] err_count;
   logic [63:0]     ld_data;
   logic [2:0]      ld_off;

   exp_t        exp_q[$];
   logic [15:0] exp_cnt;
   int          total  = 0;
   int          passed = 0;
   bit          last_acc;

   always #5 clk = ~clk;

   extensor_pipe #(.XLEN(XLEN), .DEPTH(DEPTH), .ERRW(ERRW)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .instr     (instr),
      .sel       (sel),
      .auto_sel  (auto_sel),
`ifdef EXTENSOR_LOAD_EN
      .ld_data   (ld_data),
      .ld_off    (ld_off),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .imm       (imm),
      .fmt       (fmt),
      .err       (err),
      .err_count (err_count)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Sign-extend an n-bit unsigned value held in 64 bits (mod-2^64 arithmetic).
   function automatic logic [63:0] sx(input logic [63:0] v, input int n);
      logic [63:0] half, full;
      half = 64'd1 << (n - 1);
      full = 64'd1 << n;
      if (v >= half) return v - full;
      return v;
   endfunction

   function automatic exp_t model(input logic [31:0] ins, input logic [3:0] s, input bit a,
                                  input logic [63:0] ld, input logic [2:0] off);
      exp_t        e;
      int          f, op, f3, size;
      logic [63:0] w, v, bytes;
      bit          sgn;
      w  = {32'd0, ins};
      op = int'(ins & 32'h7f);
      f3 = int'((ins >> 12) & 32'd7);
      v  = 64'd0;
      if (a) begin
         if (op == 8'h13 && (f3 == 1 || f3 == 5))                          f = 5;
         else if (op == 8'h13 || op == 8'h03 || op == 8'h67 || op == 8'h73) f = 0;
         else if (op == 8'h23)                                              f = 1;
         else if (op == 8'h63)                                              f = 2;
         else if (op == 8'h37 || op == 8'h17)                               f = 3;
         else if (op == 8'h6f)                                              f = 4;
         else                                                               f = 7;
      end else if (s <= 4'd5) f = int'(s);
      else if (LOAD_EN && s >= 4'd8 && s <= 4'd14) f = 6;
      else f = 7;
      case (f)
         0: v = sx(w >> 20, 12);
         1: v = sx(((w >> 25) << 5) + ((w >> 7) & 64'd31), 12);
         2: v = sx(((w >> 31) & 64'd1) * 64'd4096 + ((w >> 7) & 64'd1) * 64'd2048
                   + ((w >> 25) & 64'd63) * 64'd32 + ((w >> 8) & 64'd15) * 64'd2, 13);
         3: v = sx(w & 64'hFFFF_F000, 32);
         4: v = sx(((w >> 31) & 64'd1) * 64'd1048576 + ((w >> 12) & 64'd255) * 64'd4096
                   + ((w >> 20) & 64'd1) * 64'd2048 + ((w >> 21) & 64'd1023) * 64'd2, 21);
         5: v = (w >> 20) & 64'd63;
         6: begin
            case (s)
               4'd8, 4'd12: size = 1;
               4'd9, 4'd13: size = 2;
               4'd10, 4'd14: size = 4;
               default:     size = 8;
            endcase
            sgn = (s <= 4'd11);
            if ((int'(off) % size) != 0) f = 7;
            else begin
               bytes = ld >> (int'(off) * 8);
               if (size == 8) v = bytes;
               else begin
                  v = bytes & ((64'd1 << (8 * size)) - 64'd1);
                  if (sgn) v = sx(v, 8 * size);
               end
            end
         end
         default: v = 64'd0;
      endcase
      e.fmt = 3'(f);
      e.err = (f == 7);
      e.imm = (f == 7) ? 64'd0 : v;
      return e;
   endfunction

   // Monitor: every DUT pop is compared with the oldest expected entry.
   always @(negedge clk) begin
      if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) chk("unexpected_pop", 64'd1, 64'd0);
         else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("imm", 64'(imm), e.imm);
            chk("fmt", 64'(fmt), 64'(e.fmt));
            chk("err", 64'(err), 64'(e.err));
         end
      end
   end

   // One clock of stimulus; inputs change 1 time unit after the rising edge.
   task automatic step(input bit v, input logic [3:0] s, input logic [31:0] ins, input bit a,
                       input bit fl, input bit rdy, input bit rst);
      exp_t e;
      bit   acc;
      in_valid = v; sel = s; instr = ins; auto_sel = a; flush = fl; out_ready = rdy; reset = rst;
      acc = v && (in_ready === 1'b1) && !fl && !rst;
      e = model(ins, s, a, ld_data, ld_off);
      if (acc) exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (rst) begin
         exp_q.delete();
         exp_cnt = 16'd0;
      end else if (fl) exp_q.delete();
      else if (acc && e.err && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      last_acc = acc;
      chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      chk("in_ready", 64'(in_ready), 64'(exp_q.size() != DEPTH));
      chk("err_count", 64'(err_count), 64'(exp_cnt));
   endtask

   initial begin
      bit done;
      ld_data = 64'd0; ld_off = 3'd0; exp_cnt = 16'd0;
      step(0, 4'd0, 32'd0, 0, 0, 0, 1);
      step(0, 4'd0, 32'd0, 0, 0, 0, 1);
      chk("rst_imm", 64'(imm), 64'd0);
      chk("rst_fmt", 64'(fmt), 64'd0);
      chk("rst_err", 64'(err), 64'd0);

      // I-type all-ones immediate, one-cycle latency.
      step(1, 4'd0, 32'hFFF00093, 0, 0, 1, 0);
      chk("i_imm", 64'(imm), 64'hFFFF_FFFF_FFFF_FFFF);
      chk("i_fmt", 64'(fmt), 64'd0);
      step(0, 4'd0, 32'd0, 0, 0, 1, 0);

      // Auto-decoded branch then lui.
      step(1, 4'd0, 32'hFE000EE3, 1, 0, 1, 0);
      chk("beq_imm", 64'(imm), 64'hFFFF_FFFF_FFFF_FFFC);
      chk("beq_fmt", 64'(fmt), 64'd2);
      step(1, 4'd0, 32'h800002B7, 1, 0, 1, 0);
      chk("lui_imm", 64'(imm), 64'hFFFF_FFFF_8000_0000);
      chk("lui_fmt", 64'(fmt), 64'd3);
      step(0, 4'd0, 32'd0, 0, 0, 1, 0);

      // Back-pressure: fill, hold the third word, then drain.
      step(1, 4'd1, 32'h00A12423, 0, 0, 0, 0);
      step(1, 4'd4, 32'h7FFFF0EF, 0, 0, 0, 0);
      chk("full_in_ready", 64'(in_ready), 64'd0);
      step(1, 4'd2, 32'h80000863, 0, 0, 0, 0);
      chk("held_in_ready", 64'(in_ready), 64'd0);
      done = 0;
      for (int i = 0; i < 8 && !done; i++) begin
         step(1, 4'd2, 32'h80000863, 0, 0, 1, 0);
         done = last_acc;
      end
      chk("third_accepted", 64'(done), 64'd1);
      repeat (3) step(0, 4'd0, 32'd0, 0, 0, 1, 0);

      // Illegal entries, then illegal accept blocked by flush.
      step(1, 4'd7, 32'h12345678, 0, 0, 1, 0);
      step(1, 4'd7, 32'h9ABCDEF0, 0, 0, 1, 0);
      step(0, 4'd0, 32'd0, 0, 0, 1, 0);
      chk("err_count_2", 64'(err_count), 64'd2);
      step(1, 4'd0, 32'h00100093, 0, 0, 0, 0);
      step(1, 4'd7, 32'h0, 0, 1, 0, 0);
      chk("flush_err_count", 64'(err_count), 64'd2);
      chk("flush_empty", 64'(out_valid), 64'd0);

      // Reset with two entries queued and a word in flight.
      step(1, 4'd3, 32'hABCDE000, 0, 0, 0, 0);
      step(1, 4'd5, 32'h03F00013, 0, 0, 0, 0);
      step(1, 4'd0, 32'hFFF00093, 0, 0, 0, 1);
      chk("mid_rst_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_ready", 64'(in_ready), 64'd1);
      chk("mid_rst_errcnt", 64'(err_count), 64'd0);
      chk("mid_rst_imm", 64'(imm), 64'd0);

`ifdef EXTENSOR_LOAD_EN
      step(0, 4'd0, 32'd0, 0, 0, 1, 0);
      ld_data = 64'h0000_0000_8000_0000; ld_off = 3'd3;
      step(1, 4'd8, 32'd0, 0, 0, 1, 0);
      chk("lb_imm", 64'(imm), 64'hFFFF_FFFF_FFFF_FF80);
      step(1, 4'd12, 32'd0, 0, 0, 1, 0);
      chk("lbu_imm", 64'(imm), 64'h0000_0000_0000_0080);
`endif

      // Randomised traffic with occasional flush and reset.
      for (int i = 0; i < 400; i++) begin
         logic [31:0] ins;
         logic [6:0]  ops [10];
         ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h33};
         ins = $urandom;
         if ($urandom_range(0, 3) != 0) ins[6:0] = ops[$urandom_range(0, 9)];
         ld_data = {$urandom, $urandom};
         ld_off  = 3'($urandom_range(0, 7));
         step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), ins, $urandom_range(0, 1) == 1,
              $urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
      end
      repeat (4) step(0, 4'd0, 32'd0, 0, 0, 1, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
